// File: rtl/rede_taylor_core.sv
// rede_taylor_core
//
// One processing core of the Taylor-series network. Each period it raises a
// one-cycle sample request, captures the broadcast sample x, evaluates
// C[ORDER]*x^ORDER + ... + C[0] in fixed point with Horner's rule (one step
// per clock, saturating to 28 bits), and presents the result with a
// one-cycle output-enable code. The period is ORDER+2 cycles and the core
// runs free with no stall input.
//
// Ports:
//   clk     in   1   rising-edge clock
//   rst     in   1   asynchronous active-low reset
//   io_in   in  19   broadcast sample x, signed Q(FRAC); sampled only in REQ
//   io_out  out 28   polynomial result, signed Q(FRAC); held until next OUT
//   req_in  out  4   request code: 0 idle, 1 sample request (one cycle)
//   out_en  out  4   output code: 0 idle, 1 io_out valid (one cycle)

module rede_taylor_core #(
    parameter int                 ORDER = 3,
    parameter int                 FRAC  = 14,
    parameter logic signed [18:0] C0    = 19'sd16384,
    parameter logic signed [18:0] C1    = 19'sd16384,
    parameter logic signed [18:0] C2    = 19'sd8192,
    parameter logic signed [18:0] C3    = 19'sd2731,
    parameter logic signed [18:0] C4    = 19'sd0,
    parameter logic signed [18:0] C5    = 19'sd0,
    parameter logic signed [18:0] C6    = 19'sd0,
    parameter logic signed [18:0] C7    = 19'sd0,
    parameter logic signed [18:0] C8    = 19'sd0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [18:0] io_in,
    output logic signed [27:0] io_out,
    output logic        [3:0]  req_in,
    output logic        [3:0]  out_en
);

    localparam logic signed [47:0] SAT_MAX = 48'sd134217727;
    localparam logic signed [47:0] SAT_MIN = -48'sd134217728;

    localparam logic signed [18:0] COEF_TAB [0:8] = '{C0, C1, C2, C3, C4, C5, C6, C7, C8};

    // PEND is the state reset lands in; it exists so that the REQ pulse
    // (a registered output) appears in the first cycle after release.
    typedef enum logic [1:0] {
        ST_PEND = 2'd0,
        ST_REQ  = 2'd1,
        ST_CALC = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    state_t             state_reg,  state_next;
    logic        [3:0]  k_reg,      k_next;
    logic signed [27:0] acc_reg,    acc_next;
    logic signed [18:0] x_reg,      x_next;
    logic signed [27:0] io_out_reg, io_out_next;
    logic        [3:0]  req_reg,    req_next;
    logic        [3:0]  out_reg,    out_next;

    // Coefficient table as a small constant ROM indexed by the step counter.
    logic signed [18:0] coef [0:8];

    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_coef
            assign coef[gi] = COEF_TAB[gi];
        end
    endgenerate

    // One Horner step: full 47-bit product, arithmetic shift (floor),
    // add the sign-extended coefficient in 48 bits, then clamp to 28 bits.
    logic signed [18:0] coef_k;
    logic signed [46:0] prod;
    logic signed [46:0] prod_shift;
    logic signed [47:0] sum;
    logic signed [27:0] step_sat;

    assign coef_k     = coef[k_reg];
    assign prod       = 47'(acc_reg) * 47'(x_reg);
    assign prod_shift = prod >>> FRAC;
    assign sum        = 48'(prod_shift) + 48'(coef_k);

    always_comb begin
        step_sat = sum[27:0];
        if (sum > SAT_MAX) begin
            step_sat = SAT_MAX[27:0];
        end else if (sum < SAT_MIN) begin
            step_sat = SAT_MIN[27:0];
        end
    end

    always_comb begin
        state_next  = state_reg;
        k_next      = k_reg;
        acc_next    = acc_reg;
        x_next      = x_reg;
        io_out_next = io_out_reg;
        req_next    = 4'd0;
        out_next    = 4'd0;
        case (state_reg)
            ST_PEND: begin
                req_next   = 4'd1;
                state_next = ST_REQ;
            end
            ST_REQ: begin
                x_next     = io_in;
                acc_next   = 28'(coef[ORDER]);
                k_next     = 4'(ORDER - 1);
                state_next = ST_CALC;
            end
            ST_CALC: begin
                acc_next = step_sat;
                if (k_reg == 4'd0) begin
                    io_out_next = step_sat;
                    out_next    = 4'd1;
                    state_next  = ST_OUT;
                end else begin
                    k_next = k_reg - 4'd1;
                end
            end
            ST_OUT: begin
                req_next   = 4'd1;
                state_next = ST_REQ;
            end
            default: begin
                state_next = ST_PEND;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= ST_PEND;
            k_reg      <= 4'd0;
            acc_reg    <= 28'sd0;
            x_reg      <= 19'sd0;
            io_out_reg <= 28'sd0;
            req_reg    <= 4'd0;
            out_reg    <= 4'd0;
        end else begin
            state_reg  <= state_next;
            k_reg      <= k_next;
            acc_reg    <= acc_next;
            x_reg      <= x_next;
            io_out_reg <= io_out_next;
            req_reg    <= req_next;
            out_reg    <= out_next;
        end
    end

    assign io_out = io_out_reg;
    assign req_in = req_reg;
    assign out_en = out_reg;

endmodule

// File: tb/tb_rede_taylor_core.sv
// Testbench for rede_taylor_core: default-parameter core under directed and
// random stimulus checked against a plain-arithmetic polynomial model, plus
// two saturating-coefficient cores for the clamp boundaries.

module tb_rede_taylor_core;

    localparam int ORDER = 3;
    localparam int FRAC  = 14;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic signed [18:0] io_in = 19'sd0;
    logic signed [27:0] io_out;
    logic        [3:0]  req_in;
    logic        [3:0]  out_en;

    logic signed [18:0] io_in_a = 19'sd262143;
    logic signed [27:0] io_out_a;
    logic        [3:0]  req_in_a;
    logic        [3:0]  out_en_a;

    logic signed [18:0] io_in_b = -19'sd262144;
    logic signed [27:0] io_out_b;
    logic        [3:0]  req_in_b;
    logic        [3:0]  out_en_b;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    rede_taylor_core dut (
        .clk    (clk),
        .rst    (rst),
        .io_in  (io_in),
        .io_out (io_out),
        .req_in (req_in),
        .out_en (out_en)
    );

    rede_taylor_core #(
        .C0(19'sd262143), .C1(19'sd262143), .C2(19'sd262143), .C3(19'sd262143)
    ) dut_sat_pos (
        .clk    (clk),
        .rst    (rst),
        .io_in  (io_in_a),
        .io_out (io_out_a),
        .req_in (req_in_a),
        .out_en (out_en_a)
    );

    rede_taylor_core #(
        .C0(19'sd0), .C1(19'sd0), .C2(19'sd0), .C3(19'sd262143)
    ) dut_sat_neg (
        .clk    (clk),
        .rst    (rst),
        .io_in  (io_in_b),
        .io_out (io_out_b),
        .req_in (req_in_b),
        .out_en (out_en_b)
    );

    // Reference: evaluate the polynomial with 64-bit integers, flooring the
    // scaled product and clamping to the 28-bit signed range after each step.
    function automatic logic signed [27:0] ref_poly(input logic signed [18:0] x);
        longint c [0:8];
        longint acc;
        longint xl;
        c  = '{16384, 16384, 8192, 2731, 0, 0, 0, 0, 0};
        xl = longint'(x);
        acc = c[ORDER];
        for (int k = ORDER - 1; k >= 0; k--) begin
            acc = ((acc * xl) >>> FRAC) + c[k];
            if (acc > 134217727) acc = 134217727;
            else if (acc < -134217728) acc = -134217728;
        end
        return 28'(acc);
    endfunction

    // Waits for the next request, presents x in that cycle, optionally
    // scrambles io_in in every other cycle, and returns what the core shows
    // at its output pulse. Leaves the caller at the out_en negedge.
    task automatic drive_txn(input logic signed [18:0] x, input bit scramble,
                             output logic signed [27:0] got, output int pre,
                             output int lat, output bit timeout,
                             output bit held, output bit overlap);
        logic signed [27:0] prev;
        prev    = io_out;
        got     = '0;
        pre     = 0;
        lat     = 0;
        timeout = 1'b0;
        held    = 1'b1;
        overlap = 1'b0;
        while (req_in !== 4'd1 && pre < 20) begin
            @(negedge clk);
            pre++;
            if (scramble && req_in !== 4'd1) io_in = 19'($urandom);
        end
        if (req_in !== 4'd1) begin
            timeout = 1'b1;
        end else begin
            io_in = x;
            do begin
                @(negedge clk);
                lat++;
                if (req_in === 4'd1 && out_en === 4'd1) overlap = 1'b1;
                if (out_en !== 4'd1) begin
                    if (io_out !== prev) held = 1'b0;
                    if (scramble) io_in = 19'($urandom);
                end
            end while (out_en !== 4'd1 && lat < 20);
            if (out_en !== 4'd1) timeout = 1'b1;
            got = io_out;
        end
    endtask

    // Called at the negedge where rst is released; records the cycle index
    // of the first request and first output pulse.
    task automatic measure_restart(output int req_at, output int out_at,
                                   output logic signed [27:0] got);
        req_at = -1;
        out_at = -1;
        got    = '0;
        for (int i = 1; i <= 12 && out_at < 0; i++) begin
            @(negedge clk);
            if (req_in === 4'd1 && req_at < 0) req_at = i;
            if (out_en === 4'd1) begin
                out_at = i;
                got    = io_out;
            end
        end
    endtask

    task automatic test_reset();
        int req_at, out_at;
        logic signed [27:0] got;
        rst   = 1'b0;
        io_in = 19'sd0;
        repeat (3) @(negedge clk);
        vectors++;
        if (io_out !== 28'sd0) begin
            miscompares++;
            $display("FAIL reset_io_out got=%0d exp=0", io_out);
        end
        vectors++;
        if (req_in !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_req_in got=%0d exp=0", req_in);
        end
        vectors++;
        if (out_en !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_out_en got=%0d exp=0", out_en);
        end
        rst = 1'b1;
        measure_restart(req_at, out_at, got);
        $display("txn reset_release req_at=%0d out_at=%0d io_out=%0d", req_at, out_at, got);
        vectors++;
        if (req_at !== 1) begin
            miscompares++;
            $display("FAIL reset_req_cycle got=%0d exp=1", req_at);
        end
        vectors++;
        if (out_at !== 5) begin
            miscompares++;
            $display("FAIL reset_out_cycle got=%0d exp=5", out_at);
        end
        vectors++;
        if (got !== 28'sd16384) begin
            miscompares++;
            $display("FAIL reset_first_result got=%0d exp=16384", got);
        end
    endtask

    task automatic test_saturation();
        int n;
        n = 0;
        while (out_en_a !== 4'd1 && n < 12) begin
            @(negedge clk);
            n++;
        end
        $display("txn sat pos=%0d neg=%0d", io_out_a, io_out_b);
        vectors++;
        if (out_en_a !== 4'd1 || io_out_a !== 28'sd134217727) begin
            miscompares++;
            $display("FAIL sat_pos en=%0d got=%0d exp=134217727", out_en_a, io_out_a);
        end
        vectors++;
        if (out_en_b !== 4'd1 || io_out_b !== -28'sd134217728) begin
            miscompares++;
            $display("FAIL sat_neg en=%0d got=%0d exp=-134217728", out_en_b, io_out_b);
        end
    endtask

    task automatic test_free_run();
        logic signed [18:0] xs   [3];
        logic signed [27:0] exps [3];
        logic signed [27:0] got;
        int pre, lat;
        bit timeout, held, overlap;
        xs   = '{19'sd0, 19'sd16384, -19'sd16384};
        exps = '{28'sd16384, 28'sd43691, 28'sd5461};
        for (int i = 0; i < 3; i++) begin
            drive_txn(xs[i], 1'b0, got, pre, lat, timeout, held, overlap);
            $display("txn free_run x=%0d io_out=%0d exp=%0d period=%0d", xs[i], got, exps[i], pre + lat);
            vectors++;
            if (timeout || got !== exps[i]) begin
                miscompares++;
                $display("FAIL free_run_value x=%0d got=%0d exp=%0d timeout=%0d", xs[i], got, exps[i], timeout);
            end
            vectors++;
            if (pre + lat !== ORDER + 2) begin
                miscompares++;
                $display("FAIL free_run_period got=%0d exp=%0d", pre + lat, ORDER + 2);
            end
            vectors++;
            if (!held || overlap) begin
                miscompares++;
                $display("FAIL free_run_hold held=%0d overlap=%0d exp held=1 overlap=0", held, overlap);
            end
        end
    endtask

    task automatic test_input_isolation();
        logic signed [18:0] x;
        logic signed [27:0] got, exp;
        int pre, lat;
        bit timeout, held, overlap;
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) x = 19'($urandom);
            else x = 19'(int'($urandom_range(65535)) - 32768);
            exp = ref_poly(x);
            drive_txn(x, 1'b1, got, pre, lat, timeout, held, overlap);
            $display("txn isolate x=%0d io_out=%0d exp=%0d lat=%0d", x, got, exp, lat);
            vectors++;
            if (timeout || got !== exp) begin
                miscompares++;
                $display("FAIL isolate_value x=%0d got=%0d exp=%0d timeout=%0d", x, got, exp, timeout);
            end
            vectors++;
            if (lat !== ORDER + 1 || overlap || !held) begin
                miscompares++;
                $display("FAIL isolate_timing lat=%0d overlap=%0d held=%0d exp lat=%0d", lat, overlap, held, ORDER + 1);
            end
        end
    endtask

    task automatic check_async_clear(input string tag);
        #2 rst = 1'b0;
        #1;
        vectors++;
        if (io_out !== 28'sd0 || req_in !== 4'd0 || out_en !== 4'd0) begin
            miscompares++;
            $display("FAIL %s_async_clear io_out=%0d req_in=%0d out_en=%0d exp all 0", tag, io_out, req_in, out_en);
        end
    endtask

    task automatic check_restart(input string tag);
        logic signed [18:0] x;
        logic signed [27:0] got, exp;
        int req_at, out_at;
        @(negedge clk);
        @(negedge clk);
        x     = 19'(int'($urandom_range(65535)) - 32768);
        exp   = ref_poly(x);
        io_in = x;
        rst   = 1'b1;
        measure_restart(req_at, out_at, got);
        $display("txn %s_restart x=%0d req_at=%0d out_at=%0d io_out=%0d exp=%0d", tag, x, req_at, out_at, got, exp);
        vectors++;
        if (req_at !== 1 || out_at !== 5) begin
            miscompares++;
            $display("FAIL %s_restart_timing req_at=%0d out_at=%0d exp 1 and 5", tag, req_at, out_at);
        end
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s_restart_value got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic test_mid_reset_calc();
        int n;
        n = 0;
        while (req_in !== 4'd1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        io_in = 19'sd16384;
        @(negedge clk);
        @(negedge clk);
        check_async_clear("calc");
        check_restart("calc");
    endtask

    task automatic test_mid_reset_out();
        logic signed [27:0] got;
        int pre, lat;
        bit timeout, held, overlap;
        drive_txn(19'sd16384, 1'b0, got, pre, lat, timeout, held, overlap);
        vectors++;
        if (timeout || out_en !== 4'd1 || got !== 28'sd43691) begin
            miscompares++;
            $display("FAIL out_pulse_before_reset out_en=%0d got=%0d exp=43691", out_en, got);
        end
        check_async_clear("out");
        check_restart("out");
    endtask

    task automatic test_back_to_back();
        logic signed [18:0] x;
        logic signed [27:0] got, exp;
        int pre, lat;
        bit timeout, held, overlap;
        for (int i = 0; i < 8; i++) begin
            x   = 19'(int'($urandom_range(49152)) - 24576);
            exp = ref_poly(x);
            drive_txn(x, 1'b0, got, pre, lat, timeout, held, overlap);
            $display("txn b2b x=%0d io_out=%0d exp=%0d period=%0d", x, got, exp, pre + lat);
            vectors++;
            if (timeout || got !== exp || pre + lat !== ORDER + 2) begin
                miscompares++;
                $display("FAIL b2b x=%0d got=%0d exp=%0d period=%0d exp_period=%0d", x, got, exp, pre + lat, ORDER + 2);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_saturation();
        test_free_run();
        test_input_isolation();
        test_mid_reset_calc();
        test_mid_reset_out();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
